// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and types for the memory-access pipeline stage.
package mem_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        is_jal;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  dest_reg;
        logic [31:0] pc4;
        logic [31:0] memory_data;
        logic [31:0] alu_output;
    } wb_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half lane of a read word and extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_extend,
    output logic [31:0] data
);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        b       = shifted[7:0];
        h       = addr[1] ? rdata[31:16] : rdata[15:0];
        data    = size == SIZE_BYTE ? {{24{sign_extend & b[7]}}, b} :
                  size == SIZE_HALF ? {{16{sign_extend & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; drives the data-memory req/ack handshake, stalls upstream
// while a transaction is outstanding and registers the MEM/WB boundary.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    input  logic        inIsJumpAndLink,
    input  logic [31:0] inPc4,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inMemToReg,
    input  logic        inRegWrite,
    input  logic [4:0]  inDestReg,
    input  logic [31:0] inAluOutput,
    input  logic [31:0] inStoreData,
    input  logic [1:0]  inSize,
    input  logic        inSignExtend,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memByteEn,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        misaligned,
    output logic        wbValid,
    output logic        wbIsJumpAndLink,
    output logic        wbMemToReg,
    output logic        wbRegWrite,
    output logic [31:0] wbPc4,
    output logic [31:0] wbMemoryData,
    output logic [31:0] wbAluOutput,
    output logic [4:0]  wbDestReg
);
    state_e      state_q, state_d;
    wb_t         wb_q, wb_d, in_wb;
    logic        req_q, req_d, we_q, we_d, mis_q, mis_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] load_data, st_wdata;
    logic [3:0]  st_be;
    logic [1:0]  a;
    logic        is_mem, is_mis, go;

    load_align u_load_align (
        .rdata       (memRdata),
        .addr        (inAluOutput[1:0]),
        .size        (inSize),
        .sign_extend (inSignExtend),
        .data        (load_data)
    );

    always_comb begin
        a        = inAluOutput[1:0];
        is_mem   = inValid & (inMemRead | inMemWrite);
        is_mis   = is_mem & ((inSize == SIZE_HALF & a[0]) | (inSize == SIZE_WORD & a != 2'b00));
        go       = is_mem & ~is_mis;
        stall    = ~rst & (state_q == IDLE ? go : ~memAck);
        st_wdata = inSize == SIZE_BYTE ? {4{inStoreData[7:0]}} :
                   inSize == SIZE_HALF ? {2{inStoreData[15:0]}} : inStoreData;
        st_be    = inSize == SIZE_BYTE ? BE_BYTE0 << a :
                   inSize == SIZE_HALF ? (a[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
        in_wb    = '{valid: inValid, is_jal: inIsJumpAndLink, mem_to_reg: inMemToReg,
                     reg_write: inRegWrite & ~is_mis, dest_reg: inDestReg, pc4: inPc4,
                     memory_data: 32'd0, alu_output: inAluOutput};
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        mis_d    = 1'b0;
        wb_d     = '0;
        if (state_q == IDLE) begin
            if (go) begin
                state_d = WAIT_ACK;
                req_d   = 1'b1;
                we_d    = inMemWrite;
                addr_d  = {inAluOutput[31:2], 2'b00};
                wdata_d = st_wdata;
                be_d    = st_be;
            end else begin
                wb_d  = in_wb;
                mis_d = is_mis;
            end
        end else if (memAck) begin
            // upstream has held the instruction, so its fields are still on the inputs
            state_d          = IDLE;
            req_d            = 1'b0;
            wb_d             = in_wb;
            wb_d.memory_data = inMemRead ? load_data : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wb_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
        end
    end

    assign memReq          = req_q;
    assign memWe           = we_q;
    assign memAddr         = addr_q;
    assign memWdata        = wdata_q;
    assign memByteEn       = be_q;
    assign misaligned      = mis_q;
    assign wbValid         = wb_q.valid;
    assign wbIsJumpAndLink = wb_q.is_jal;
    assign wbMemToReg      = wb_q.mem_to_reg;
    assign wbRegWrite      = wb_q.reg_write;
    assign wbPc4           = wb_q.pc4;
    assign wbMemoryData    = wb_q.memory_data;
    assign wbAluOutput     = wb_q.alu_output;
    assign wbDestReg       = wb_q.dest_reg;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a transaction-level memory model.
module tb_mem_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        inValid = 0, inIsJumpAndLink = 0, inMemRead = 0, inMemWrite = 0;
    logic        inMemToReg = 0, inRegWrite = 0, inSignExtend = 0, memAck = 0;
    logic [31:0] inPc4 = 0, inAluOutput = 0, inStoreData = 0, memRdata = 0;
    logic [4:0]  inDestReg = 0;
    logic [1:0]  inSize = 0;
    logic        stall, memReq, memWe, misaligned;
    logic        wbValid, wbIsJumpAndLink, wbMemToReg, wbRegWrite;
    logic [31:0] memAddr, memWdata, wbPc4, wbMemoryData, wbAluOutput;
    logic [3:0]  memByteEn;
    logic [4:0]  wbDestReg;
    int n_vec = 0, n_bad = 0;

    typedef struct {
        bit        valid, jal, rd, wr, m2r, rw, se;
        bit [31:0] pc4, alu, sd;
        bit [4:0]  dest;
        bit [1:0]  size;
    } instr_t;

    mem_stage dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inIsJumpAndLink(inIsJumpAndLink),
        .inPc4(inPc4), .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inMemToReg(inMemToReg),
        .inRegWrite(inRegWrite), .inDestReg(inDestReg), .inAluOutput(inAluOutput),
        .inStoreData(inStoreData), .inSize(inSize), .inSignExtend(inSignExtend),
        .stall(stall), .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memByteEn(memByteEn), .memAck(memAck), .memRdata(memRdata), .misaligned(misaligned),
        .wbValid(wbValid), .wbIsJumpAndLink(wbIsJumpAndLink), .wbMemToReg(wbMemToReg),
        .wbRegWrite(wbRegWrite), .wbPc4(wbPc4), .wbMemoryData(wbMemoryData),
        .wbAluOutput(wbAluOutput), .wbDestReg(wbDestReg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input bit [31:0] rd, input bit [1:0] a,
                                             input bit [1:0] size, input bit se);
        bit [31:0] v;
        if (size == 0) begin
            v = (rd >> (8 * a)) & 32'hFF;
            if (se && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (rd >> (16 * a[1])) & 32'hFFFF;
            if (se && v >= 32768) v = v | 32'hFFFF_0000;
        end else v = rd;
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input bit [31:0] d, input bit [1:0] size);
        return size == 0 ? (d & 32'hFF) * 32'h0101_0101 :
               size == 1 ? (d & 32'hFFFF) * 32'h0001_0001 : d;
    endfunction

    function automatic logic [3:0] ref_be(input bit [1:0] a, input bit [1:0] size);
        return size == 0 ? 4'(1 << a) : size == 1 ? 4'(3 << (a & 2)) : 4'hF;
    endfunction

    task automatic check_wb(input instr_t i, input bit mis, input logic [31:0] md);
        chk("wbValid", wbValid, i.valid);
        chk("wbRegWrite", wbRegWrite, mis ? 0 : i.rw);
        chk("wbMemToReg", wbMemToReg, i.m2r);
        chk("wbIsJal", wbIsJumpAndLink, i.jal);
        chk("wbPc4", wbPc4, i.pc4);
        chk("wbAlu", wbAluOutput, i.alu);
        chk("wbDest", wbDestReg, i.dest);
        chk("wbMemData", wbMemoryData, md);
    endtask

    task automatic drive(input instr_t i);
        inValid = i.valid; inIsJumpAndLink = i.jal; inPc4 = i.pc4; inMemRead = i.rd;
        inMemWrite = i.wr; inMemToReg = i.m2r; inRegWrite = i.rw; inDestReg = i.dest;
        inAluOutput = i.alu; inStoreData = i.sd; inSize = i.size; inSignExtend = i.se;
    endtask

    // called at a negedge; returns at the negedge after the instruction reaches WB
    task automatic run(input instr_t i, input int n_force, input bit rd_en, input bit [31:0] rd_val);
        bit mem, mis;
        bit [31:0] rdv;
        int n;
        mem = i.valid && (i.rd || i.wr);
        mis = mem && ((i.size == 1 && i.alu[0]) || (i.size == 2 && i.alu[1:0] != 0));
        drive(i);
        #1 chk("stall_issue", stall, mem && !mis);
        if (!mem || mis) begin
            @(posedge clk); @(negedge clk);
            check_wb(i, mis, 0);
            chk("misaligned", misaligned, mis);
            chk("memReq_idle", memReq, 0);
        end else begin
            @(posedge clk); @(negedge clk);
            chk("memReq", memReq, 1);
            chk("memWe", memWe, i.wr);
            chk("memAddr", memAddr, i.alu & ~32'd3);
            if (i.wr) begin
                chk("memWdata", memWdata, ref_wdata(i.sd, i.size));
                chk("memByteEn", memByteEn, ref_be(i.alu[1:0], i.size));
            end
            chk("bubble0", wbValid, 0);
            n = n_force > 0 ? n_force : int'($urandom_range(1, 4));
            for (int k = 1; k <= n; k++) begin
                memAck = (k == n);
                memRdata = (k == n && rd_en) ? rd_val : $urandom;
                rdv = memRdata;
                #1 chk("stall_wait", stall, k != n);
                chk("memReq_held", memReq, 1);
                chk("memAddr_held", memAddr, i.alu & ~32'd3);
                @(posedge clk); @(negedge clk);
                memAck = 0;
                if (k < n) chk("bubble", wbValid, 0);
            end
            check_wb(i, 0, i.rd ? ref_load(rdv, i.alu[1:0], i.size, i.se) : 0);
            chk("memReq_drop", memReq, 0);
            chk("misaligned_mem", misaligned, 0);
        end
    endtask

    function automatic instr_t mk(input bit rd, input bit wr, input bit [1:0] size, input bit se,
                                  input bit [31:0] alu, input bit [31:0] sd);
        instr_t i;
        i = '{valid: 1, jal: 0, rd: rd, wr: wr, m2r: rd, rw: !wr, se: se, pc4: 32'h10,
              alu: alu, sd: sd, dest: 5'd3, size: size};
        return i;
    endfunction

    initial begin
        instr_t i;
        #2;
        chk("rst_wbValid", wbValid, 0);
        chk("rst_wbAlu", wbAluOutput, 0);
        chk("rst_memReq", memReq, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_stall", stall, 0);
        chk("rst_misaligned", misaligned, 0);
        @(negedge clk) rst = 0;
        i = mk(0, 0, 2, 0, 32'h1234, 0); i.dest = 5; i.rw = 1;
        run(i, 0, 0, 0);
        run(mk(1, 0, 2, 0, 32'h100, 0), 3, 1, 32'hDEAD_BEEF);
        i = mk(0, 0, 2, 0, 32'h8, 0); i.jal = 1; i.pc4 = 32'h40; i.dest = 1;
        run(i, 0, 0, 0);
        run(mk(1, 0, 0, 1, 32'h103, 0), 1, 1, 32'h8011_2233);
        run(mk(1, 0, 0, 0, 32'h103, 0), 2, 1, 32'h8011_2233);
        run(mk(0, 1, 1, 0, 32'h202, 32'hABCD), 1, 0, 0);
        run(mk(1, 0, 2, 0, 32'h101, 0), 0, 0, 0);
        run(mk(1, 0, 1, 1, 32'h106, 0), 1, 1, 32'h8001_7FFF);
        for (int t = 0; t < 300; t++) begin
            i.valid = $urandom_range(0, 9) != 0;
            case ($urandom_range(0, 2))
                0: begin i.rd = 0; i.wr = 0; end
                1: begin i.rd = 1; i.wr = 0; end
                default: begin i.rd = 0; i.wr = 1; end
            endcase
            i.jal = !i.rd && !i.wr && $urandom_range(0, 3) == 0;
            i.m2r = i.rd; i.rw = $urandom_range(0, 1); i.se = $urandom_range(0, 1);
            i.size = 2'($urandom_range(0, 2)); i.dest = 5'($urandom);
            i.pc4 = $urandom; i.alu = $urandom; i.sd = $urandom;
            run(i, 0, 0, 0);
        end
        i = mk(1, 0, 2, 0, 32'h300, 0);
        drive(i);
        @(posedge clk); @(negedge clk);
        chk("pre_rst_req", memReq, 1);
        rst = 1;
        #1 chk("rst_mid_req", memReq, 0);
        chk("rst_mid_addr", memAddr, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_wbValid", wbValid, 0);
        @(negedge clk) rst = 0;
        inValid = 0; memAck = 1;
        @(posedge clk); @(negedge clk);
        memAck = 0;
        chk("late_ack_req", memReq, 0);
        chk("late_ack_wbValid", wbValid, 0);
        i = mk(0, 0, 2, 0, 32'h55, 0); i.rw = 1;
        run(i, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
